// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider: divided square wave, rising-edge Tick strobe, handshaked divisor reload.
// Optional programmable duty cycle via `CLKDIV_DUTY_EN (adds the DutyHigh input).
module prog_clk_div #(
   parameter int unsigned WIDTH       = 25,
   parameter int unsigned DEFAULT_DIV = 25000
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             SyncIn,
   input  logic             LoadValid,
   input  logic [WIDTH-1:0] LoadDiv,
`ifdef CLKDIV_DUTY_EN
   input  logic [WIDTH:0]   DutyHigh,
`endif
   output logic             LoadReady,
   output logic             ClkOut,
   output logic             Tick,
   output logic [WIDTH-1:0] DivActive
);

`ifdef CLKDIV_DUTY_EN
   // Phases can last up to 2*DivActive-1 cycles, so the counter needs one extra bit.
   localparam int unsigned CW = WIDTH + 1;
`else
   localparam int unsigned CW = WIDTH;
`endif

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DIV_ONE = WIDTH'(1);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);

   logic [CW-1:0]    counter;
   logic [CW-1:0]    counter_nxt;
   logic [CW-1:0]    phase_len;
   logic             clk_out_nxt;
   logic             tick_nxt;
   logic             pending;
   logic             pending_nxt;
   logic             apply;
   logic             accept;
   logic             boundary;
   logic [WIDTH-1:0] pend_div;
   logic [WIDTH-1:0] div_nxt;
   logic [WIDTH-1:0] load_div_fix;

   assign accept       = LoadValid & LoadReady;
   assign load_div_fix = (LoadDiv == '0) ? DIV_ONE : LoadDiv;

`ifdef CLKDIV_DUTY_EN
   logic [WIDTH:0] duty_active;
   logic [WIDTH:0] pend_duty;
   logic [WIDTH:0] duty_fix;
   logic [WIDTH:0] load_period;
   logic [WIDTH:0] period_len;

   assign load_period = {load_div_fix, 1'b0};
   assign period_len  = {DivActive, 1'b0};

   // Clamp against the divisor being loaded alongside, so both halves are at least one cycle.
   always_comb begin
      duty_fix = DutyHigh;
      if (DutyHigh == '0) begin
         duty_fix = (WIDTH+1)'(1);
      end else if (DutyHigh >= load_period) begin
         duty_fix = load_period - (WIDTH+1)'(1);
      end
   end

   assign phase_len = ClkOut ? duty_active : (period_len - duty_active);
`else
   assign phase_len = DivActive;
`endif

   assign boundary = En && (counter == (phase_len - CNT_ONE));

   // NOTE: combinational next-state logic uses blocking '=' and assigns every output a
   // default first, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      counter_nxt = counter;
      clk_out_nxt = ClkOut;
      tick_nxt    = 1'b0;
      div_nxt     = DivActive;
      pending_nxt = pending;
      apply       = 1'b0;

      if (SyncIn) begin
         counter_nxt = '0;
         clk_out_nxt = 1'b0;
         apply       = pending;
      end else if (En) begin
         if (boundary) begin
            counter_nxt = '0;
            clk_out_nxt = ~ClkOut;
            tick_nxt    = ~ClkOut;
            apply       = pending;
         end else begin
            counter_nxt = counter + CNT_ONE;
         end
      end

      // A pending divisor and a fresh accept are mutually exclusive: accept needs LoadReady.
      if (apply) begin
         div_nxt     = pend_div;
         pending_nxt = 1'b0;
      end
      if (accept) begin
         pending_nxt = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         counter   <= '0;
         ClkOut    <= 1'b0;
         Tick      <= 1'b0;
         DivActive <= DEF_DIV;
         pending   <= 1'b0;
         LoadReady <= 1'b1;
`ifdef CLKDIV_DUTY_EN
         duty_active <= (WIDTH+1)'(DEFAULT_DIV);
`endif
      end else begin
         counter   <= counter_nxt;
         ClkOut    <= clk_out_nxt;
         Tick      <= tick_nxt;
         DivActive <= div_nxt;
         pending   <= pending_nxt;
         LoadReady <= ~pending_nxt;
`ifdef CLKDIV_DUTY_EN
         if (apply) begin
            duty_active <= pend_duty;
         end
`endif
      end
   end

   // NOTE: the holding register is only read while pending is set, so it needs no reset.
   always_ff @(posedge Clk) begin
      if (accept) begin
         pend_div <= load_div_fix;
`ifdef CLKDIV_DUTY_EN
         pend_duty <= duty_fix;
`endif
      end
   end

   a_ready_mirrors_pending: assert property (@(posedge Clk) disable iff (Rst)
      LoadReady == ~pending);
   a_tick_on_high: assert property (@(posedge Clk) disable iff (Rst)
      Tick |-> ClkOut);
   a_counter_in_range: assert property (@(posedge Clk) disable iff (Rst)
      counter < phase_len);

endmodule
